// File: rtl/keypad_pkg.sv
// Shared definitions for the matrix keypad scanner: FSM states and the
// 4x4 hex keypad legend.
package keypad_pkg;

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2,
      ST_RELEASE  = 2'd3
   } kp_state_e;

   // Legend of the 4x4 pad, rows top to bottom: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
   function automatic logic [3:0] hex_code(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      case ({row, col})
         4'h0: code = 4'h1;
         4'h1: code = 4'h2;
         4'h2: code = 4'h3;
         4'h3: code = 4'hA;
         4'h4: code = 4'h4;
         4'h5: code = 4'h5;
         4'h6: code = 4'h6;
         4'h7: code = 4'hB;
         4'h8: code = 4'h7;
         4'h9: code = 4'h8;
         4'hA: code = 4'h9;
         4'hB: code = 4'hC;
         4'hC: code = 4'hE;
         4'hD: code = 4'h0;
         4'hE: code = 4'hF;
         default: code = 4'hD;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a bus of independent asynchronous level signals.
module sync2 #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Row-scanning matrix keypad controller: drives one row at a time, debounces a
// single pressed key and reports press/hold/release with a key code.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned N_ROWS       = 4,
   parameter int unsigned N_COLS       = 4,
   parameter int unsigned SCAN_DIV     = 1000,
   parameter int unsigned DEBOUNCE_CNT = 8,
   parameter int unsigned MAP_HEX      = 1,
   localparam int unsigned KW          = ($clog2(N_ROWS * N_COLS) > 4) ? $clog2(N_ROWS * N_COLS) : 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_COLS-1:0] cols,
   output logic [N_ROWS-1:0] row_drv,
   output logic [KW-1:0]     key,
   output logic              key_valid,
   output logic              key_held,
   output logic              key_release
);

   localparam int unsigned RW = $clog2(N_ROWS);
   localparam int unsigned CW = $clog2(N_COLS);
   localparam int unsigned DW = $clog2(SCAN_DIV);
   localparam int unsigned MW = $clog2(DEBOUNCE_CNT + 1);

   logic [N_COLS-1:0] cs;

   kp_state_e         state_q, state_d;
   logic [DW-1:0]     dwell_q, dwell_d;
   logic [RW-1:0]     row_idx_q, row_idx_d;
   logic [N_ROWS-1:0] row_drv_q, row_drv_d;
   logic [CW-1:0]     col_idx_q, col_idx_d;
   logic [N_COLS-1:0] col_oh_q, col_oh_d;
   logic [MW-1:0]     match_q, match_d;
   logic [MW-1:0]     rel_q, rel_d;
   logic [KW-1:0]     key_q, key_d;
   logic              valid_q, valid_d;
   logic              held_q, held_d;
   logic              release_q, release_d;

   logic              sample_c;
   logic [RW-1:0]     row_next_c;
   logic [CW-1:0]     col_enc_c;
   logic [KW-1:0]     key_code_c;

   sync2 #(.W(N_COLS)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (cols),
      .q_o   (cs)
   );

   // Dwell timing, next-row wrap, column encoding and key code of the latched position
   always_comb begin
      sample_c   = (dwell_q == DW'(SCAN_DIV - 1));
      dwell_d    = sample_c ? '0 : dwell_q + DW'(1);
      row_next_c = (row_idx_q == RW'(N_ROWS - 1)) ? '0 : row_idx_q + RW'(1);
      col_enc_c  = '0;
      for (int unsigned i = 0; i < N_COLS; i++) begin
         if (cs[i]) col_enc_c = CW'(i);
      end
      if (MAP_HEX != 0) begin
         key_code_c = KW'(hex_code(2'(row_idx_q), 2'(col_idx_q)));
      end else begin
         key_code_c = KW'(row_idx_q) * KW'(N_COLS) + KW'(col_idx_q);
      end
   end

   // Next-state logic; every decision is taken only on the sample cycle
   always_comb begin
      state_d   = state_q;
      row_idx_d = row_idx_q;
      col_idx_d = col_idx_q;
      col_oh_d  = col_oh_q;
      match_d   = match_q;
      rel_d     = rel_q;
      key_d     = key_q;
      valid_d   = 1'b0;
      held_d    = held_q;
      release_d = 1'b0;

      if (sample_c) begin
         case (state_q)
            ST_SCAN: begin
               if ($onehot(cs)) begin
                  col_idx_d = col_enc_c;
                  col_oh_d  = cs;
                  match_d   = '0;
                  state_d   = ST_DEBOUNCE;
               end else begin
                  row_idx_d = row_next_c;
               end
            end
            ST_DEBOUNCE: begin
               if (cs == col_oh_q) begin
                  if (match_q == MW'(DEBOUNCE_CNT - 1)) begin
                     key_d   = key_code_c;
                     valid_d = 1'b1;
                     held_d  = 1'b1;
                     match_d = '0;
                     state_d = ST_HELD;
                  end else begin
                     match_d = match_q + MW'(1);
                  end
               end else begin
                  match_d   = '0;
                  row_idx_d = row_next_c;
                  state_d   = ST_SCAN;
               end
            end
            ST_HELD: begin
               // The first zero sample already counts towards the release
               if (cs == '0) begin
                  if (DEBOUNCE_CNT <= 1) begin
                     release_d = 1'b1;
                     held_d    = 1'b0;
                     rel_d     = '0;
                     row_idx_d = row_next_c;
                     state_d   = ST_SCAN;
                  end else begin
                     rel_d   = MW'(1);
                     state_d = ST_RELEASE;
                  end
               end
            end
            ST_RELEASE: begin
               if (cs == '0) begin
                  if (rel_q == MW'(DEBOUNCE_CNT - 1)) begin
                     release_d = 1'b1;
                     held_d    = 1'b0;
                     rel_d     = '0;
                     row_idx_d = row_next_c;
                     state_d   = ST_SCAN;
                  end else begin
                     rel_d = rel_q + MW'(1);
                  end
               end else begin
                  rel_d   = '0;
                  state_d = ST_HELD;
               end
            end
            default: state_d = ST_SCAN;
         endcase
      end

      row_drv_d = N_ROWS'(1) << row_idx_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_SCAN;
         dwell_q   <= '0;
         row_idx_q <= '0;
         row_drv_q <= N_ROWS'(1);
         col_idx_q <= '0;
         col_oh_q  <= '0;
         match_q   <= '0;
         rel_q     <= '0;
         key_q     <= '0;
         valid_q   <= 1'b0;
         held_q    <= 1'b0;
         release_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         dwell_q   <= dwell_d;
         row_idx_q <= row_idx_d;
         row_drv_q <= row_drv_d;
         col_idx_q <= col_idx_d;
         col_oh_q  <= col_oh_d;
         match_q   <= match_d;
         rel_q     <= rel_d;
         key_q     <= key_d;
         valid_q   <= valid_d;
         held_q    <= held_d;
         release_q <= release_d;
      end
   end

   assign row_drv     = row_drv_q;
   assign key         = key_q;
   assign key_valid   = valid_q;
   assign key_held    = held_q;
   assign key_release = release_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: hex and linear instances share one keypad, checked
// once per scan sample against a sample-level model of the pad behaviour.
module tb_keypad_scanner;

   localparam int unsigned NR = 4;
   localparam int unsigned NC = 4;
   localparam int unsigned SD = 4;
   localparam int unsigned DB = 3;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] cols  = 4'h0;

   logic [3:0] row_drv_h, key_h, row_drv_l, key_l;
   logic       valid_h, held_h, release_h, valid_l, held_l, release_l;

   keypad_scanner #(.N_ROWS(NR), .N_COLS(NC), .SCAN_DIV(SD), .DEBOUNCE_CNT(DB), .MAP_HEX(1)) u_dut_hex (
      .clk(clk), .rst_n(rst_n), .cols(cols), .row_drv(row_drv_h), .key(key_h),
      .key_valid(valid_h), .key_held(held_h), .key_release(release_h)
   );

   keypad_scanner #(.N_ROWS(NR), .N_COLS(NC), .SCAN_DIV(SD), .DEBOUNCE_CNT(DB), .MAP_HEX(0)) u_dut_lin (
      .clk(clk), .rst_n(rst_n), .cols(cols), .row_drv(row_drv_l), .key(key_l),
      .key_valid(valid_l), .key_held(held_l), .key_release(release_l)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   int hex_tab [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

   // Sample-level model: scanned row, candidate column and run lengths
   int m_row, m_cand, m_run, m_zero, e_key_h, e_key_l;
   bit m_held, e_valid, e_release;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int col_of(input logic [3:0] c);
      for (int i = 0; i < 4; i++) if (c[i]) return i;
      return -1;
   endfunction

   function automatic logic [3:0] kp(input bit pressed, input int prow, input int pcol);
      logic [3:0] one;
      one = 4'b0001;
      return (pressed && (m_row == prow)) ? (one << pcol) : 4'b0000;
   endfunction

   task automatic model_reset();
      m_row = 0; m_cand = -1; m_run = 0; m_zero = 0; m_held = 0;
      e_valid = 0; e_release = 0; e_key_h = 0; e_key_l = 0;
   endtask

   task automatic model_step(input logic [3:0] c);
      e_valid   = 0;
      e_release = 0;
      if (m_held) begin
         if (c == 4'h0) begin
            m_zero++;
            if (m_zero == DB) begin
               m_held = 0; e_release = 1; m_row = (m_row + 1) % NR;
            end
         end else begin
            m_zero = 0;
         end
      end else if (m_cand < 0) begin
         if ($countones(c) == 1) begin
            m_cand = col_of(c); m_run = 1;
         end else begin
            m_row = (m_row + 1) % NR;
         end
      end else if (col_of(c) == m_cand && $countones(c) == 1) begin
         m_run++;
         if (m_run == DB + 1) begin
            m_held = 1; e_valid = 1; m_zero = 0;
            e_key_h = hex_tab[m_row * 4 + m_cand];
            e_key_l = m_row * 4 + m_cand;
            m_cand = -1;
         end
      end else begin
         m_cand = -1; m_row = (m_row + 1) % NR;
      end
   endtask

   task automatic check_outputs();
      check("row_drv_hex", row_drv_h, 32'(1 << m_row));
      check("row_drv_lin", row_drv_l, 32'(1 << m_row));
      check("key_hex", key_h, e_key_h);
      check("key_lin", key_l, e_key_l);
      check("key_valid", {valid_l, valid_h}, {e_valid, e_valid});
      check("key_held", {held_l, held_h}, {m_held, m_held});
      check("key_release", {release_l, release_h}, {e_release, e_release});
   endtask

   // Drive one sample's worth of column value; called just after a sample edge
   task automatic sample(input logic [3:0] c);
      cols = c;
      repeat (2) @(posedge clk);
      #1;
      check("pulse_width", {valid_h, release_h, valid_l, release_l}, 0);
      check("row_stable", row_drv_h, 32'(1 << m_row));
      repeat (SD - 2) @(posedge clk);
      #1;
      model_step(c);
      check_outputs();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_row_drv", {row_drv_l, row_drv_h}, 8'h11);
      check("rst_key", {key_l, key_h}, 0);
      check("rst_flags", {valid_h, held_h, release_h, valid_l, held_l, release_l}, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      int krow, kcol, plen, rlen;
      logic [3:0] c;
      model_reset();
      #1;
      do_reset();

      // Idle scan rotation
      repeat (5) sample(4'h0);

      // Press row 2 / column 1, then release
      repeat (8) sample(kp(1, 2, 1));
      check("press_key_hex", key_h, 8);
      check("press_key_lin", key_l, 9);
      check("press_held", held_h, 1);
      repeat (3) sample(4'h0);
      check("release_key_kept", key_h, 8);
      check("release_held", held_h, 0);

      // One-sample bounce at row 2 resumes scanning at row 3
      for (int n = 0; n < 8 && m_row != 2; n++) sample(4'h0);
      sample(4'b0010);
      sample(4'h0);
      check("bounce_row", row_drv_h, 4'b1000);
      check("bounce_key", key_h, 8);

      // Two columns at once is never captured
      repeat (8) sample(4'b0110);
      check("multi_ignored", held_h, 0);

      // Reset while debouncing, key kept down and re-accepted afterwards
      for (int n = 0; n < 8 && m_row != 0; n++) sample(4'h0);
      repeat (2) sample(kp(1, 0, 2));
      do_reset();
      repeat (8) sample(kp(1, 0, 2));
      check("reaccept_key", key_h, 3);
      repeat (4) sample(4'h0);

      // Random presses with bounce noise and occasional resets
      repeat (40) begin
         if ($urandom_range(0, 19) == 0) do_reset();
         krow = int'($urandom_range(0, 3));
         kcol = int'($urandom_range(0, 3));
         plen = int'($urandom_range(0, 12));
         rlen = int'($urandom_range(0, 8));
         for (int n = 0; n < plen + rlen; n++) begin
            c = kp(n < plen, krow, kcol);
            if ($urandom_range(0, 9) == 0) c = 4'($urandom_range(0, 15));
            sample(c);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter N_ROWS, default 4, number of driven keypad rows (2..8).
REQ-002 SHALL have parameter N_COLS, default 4, number of sensed keypad columns (2..8).
REQ-003 SHALL have parameter SCAN_DIV, default 1000, clocks per row dwell (min 4).
REQ-004 SHALL have parameter DEBOUNCE_CNT, default 8, consecutive matching samples needed to accept a press or release (min 1).
REQ-005 SHALL have parameter MAP_HEX, default 1: 1 = hex layout 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D, legal only with 4x4; 0 = linear index.
REQ-006 SHALL derive localparam KW = max(4, clog2(N_ROWS*N_COLS)).
REQ-007 clk  input  1  single system clock, rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 cols  input  N_COLS  column sense lines, active-high, asynchronous to clk.
REQ-010 row_drv  output  N_ROWS  row drive, one-hot active-high.
REQ-011 key  output  KW  code of last accepted key.
REQ-012 key_valid  output  1  one-cycle pulse when key updates on an accepted press.
REQ-013 key_held  output  1  high while the accepted key remains pressed.
REQ-014 key_release  output  1  one-cycle pulse on accepted release.

Function
REQ-015 SHALL pass cols through a 2-flop synchroniser; all decisions use synchronised cols (cs).
REQ-016 SHALL run dwell counter 0..SCAN_DIV-1, wrapping; a "sample" occurs on the cycle counter == SCAN_DIV-1.
REQ-017 SHALL implement FSM states SCAN, DEBOUNCE, HELD, RELEASE.
REQ-018 SCAN: at each sample, if cs is exactly one-hot, latch row/col index, hold row_drv, go DEBOUNCE; else advance row_drv one position (row N_ROWS-1 wraps to row 0).
REQ-019 SCAN: cs with zero or two-plus bits set SHALL be ignored (no capture, scan continues).
REQ-020 DEBOUNCE: each sample with cs equal to latched one-hot column increments match count; reaching DEBOUNCE_CNT asserts key_valid, key_held, updates key, goes HELD.
REQ-021 DEBOUNCE: any non-matching sample SHALL clear match count, advance row_drv, return SCAN, no output change.
REQ-022 Code: MAP_HEX=1 -> hex layout [row][col]; MAP_HEX=0 -> row*N_COLS+col zero-extended to KW.
REQ-023 HELD: samples with cs==0 go RELEASE with release count 1; other values stay HELD (second key ignored).
REQ-024 RELEASE: each cs==0 sample increments release count; reaching DEBOUNCE_CNT pulses key_release, clears key_held, advances row_drv, goes SCAN; any nonzero sample returns HELD, count cleared.
REQ-025 key SHALL hold its value after release until the next accepted press.
REQ-026 Press latency SHALL be DEBOUNCE_CNT+1 samples after first one-hot sample; key_valid asserts the clock after the accepting sample.
REQ-027 key_valid and key_release SHALL never assert in the same cycle or for more than one cycle.

Reset
REQ-028 On rst_n low, immediately: state=SCAN, row_drv=1 (row 0), dwell/match/release counters=0, key=0, key_valid=0, key_held=0, key_release=0, synchroniser flops=0.
REQ-029 Reset mid-press SHALL discard the press; a key still held after reset SHALL be re-debounced from SCAN.

Structure
REQ-030 SHALL place FSM state enum and hex-layout lookup function in shared package keypad_pkg.
REQ-031 SHALL instantiate one sub-module, sync2 (parametrised-width 2-flop synchroniser, clk/rst_n).

Verification (N_ROWS=4, N_COLS=4, SCAN_DIV=4, DEBOUNCE_CNT=3, MAP_HEX=1 unless noted)
REQ-032 Idle, no key -> row_drv cycles 0001,0010,0100,1000,0001 every 4 clocks; no pulses.
REQ-033 Hold cols=0010 while row_drv=0100 -> key=4'h8, one key_valid pulse, key_held=1; release -> key_release after 3 zero samples, key stays 8.
REQ-034 MAP_HEX=0, same press -> key=9.
REQ-035 Bounce: cols=0010 for 1 sample, 0 next -> no key_valid, scan resumes with row 1000.
REQ-036 cols=0110 at any row -> ignored, no capture, scan continues.
REQ-037 rst_n low during DEBOUNCE -> all outputs to reset values that cycle; key still pressed -> accepted again after full debounce.
